// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a single-port byte RAM
//
// Ports
//   clk_i, reset_i            clock and asynchronous active-high reset
//   req_x_i, we_x_i           request and write-enable from requester A / B
//   addr_x_i, wdata_x_i       byte address and write data from requester A / B
//   ack_x_o                   one-cycle completion pulse to requester A / B
//   rdata_x_o, err_x_o        read data and out-of-range flag, valid with ack
//   mem_read_o, mem_write_o   RAM read / write strobes
//   address_o, write_data_o   RAM address and write data
//   mem_data_i                RAM registered read data
//   busy_o                    high while a transaction is in flight
//
// Optional feature: define RAM_ARB_BOUNDS_CHECK_EN to block RAM access for
// addresses >= ADDR_LIMIT and report them through err_x_o.
//
// Every output is a register, so a state's actions become visible in the
// cycle after the edge that performs them: strobes are seen one cycle after
// the grant edge and ack three cycles after it.
module ram_arbiter #(
  parameter int unsigned ADDR_LIMIT = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_a_i,
  input  logic       we_a_i,
  input  logic [7:0] addr_a_i,
  input  logic [7:0] wdata_a_i,
  input  logic       req_b_i,
  input  logic       we_b_i,
  input  logic [7:0] addr_b_i,
  input  logic [7:0] wdata_b_i,
  output logic       ack_a_o,
  output logic [7:0] rdata_a_o,
  output logic       err_a_o,
  output logic       ack_b_o,
  output logic [7:0] rdata_b_o,
  output logic       err_b_o,
  output logic       mem_write_o,
  output logic       mem_read_o,
  output logic [7:0] address_o,
  output logic [7:0] write_data_o,
  input  logic [7:0] mem_data_i,
  output logic       busy_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;
  state_t     state_q;
  logic       last_b_q, win_b_q, we_q, oob_q;
  logic [7:0] addr_q, wdata_q;
  logic       ack_a_q, ack_b_q, err_a_q, err_b_q;
  logic [7:0] rdata_a_q, rdata_b_q;
  logic       mem_read_q, mem_write_q, busy_q;
  logic [7:0] address_q, write_data_q;
  logic       grant_b, oob_d;
  logic [7:0] addr_sel;
  // B wins when it is alone, or when both ask and A was granted last
  assign grant_b  = req_b_i && (!req_a_i || !last_b_q);
  assign addr_sel = grant_b ? addr_b_i : addr_a_i;
`ifdef RAM_ARB_BOUNDS_CHECK_EN
  assign oob_d = {24'd0, addr_sel} >= ADDR_LIMIT;
`else
  assign oob_d = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_b_q     <= 1'b1;
      win_b_q      <= 1'b0;
      we_q         <= 1'b0;
      oob_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      err_a_q      <= 1'b0;
      err_b_q      <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          if (req_a_i || req_b_i) begin
            win_b_q  <= grant_b;
            last_b_q <= grant_b;
            we_q     <= grant_b ? we_b_i : we_a_i;
            addr_q   <= addr_sel;
            wdata_q  <= grant_b ? wdata_b_i : wdata_a_i;
            oob_q    <= oob_d;
            busy_q   <= 1'b1;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          address_q    <= addr_q;
          write_data_q <= wdata_q;
          mem_read_q   <= !we_q && !oob_q;
          mem_write_q  <= we_q && !oob_q;
          state_q      <= CAPTURE;
        end
        CAPTURE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= ACK;
        end
        ACK: begin
          // RAM data for the strobe issued two edges ago is valid now
          if (win_b_q) begin
            ack_b_q <= 1'b1;
            err_b_q <= oob_q;
            if (oob_q) rdata_b_q <= '0;
            else if (!we_q) rdata_b_q <= mem_data_i;
          end else begin
            ack_a_q <= 1'b1;
            err_a_q <= oob_q;
            if (oob_q) rdata_a_q <= '0;
            else if (!we_q) rdata_a_q <= mem_data_i;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ack_a_o      = ack_a_q;
  assign ack_b_o      = ack_b_q;
  assign err_a_o      = err_a_q;
  assign err_b_o      = err_b_q;
  assign rdata_a_o    = rdata_a_q;
  assign rdata_b_o    = rdata_b_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign address_o    = address_q;
  assign write_data_o = write_data_q;
  assign busy_o       = busy_q;
endmodule
